// File: rtl/nbit_seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package nbit_seq_divider_pkg;

  // FSM encoding for the divider control.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Replicated to the operand width to form the divide-by-zero quotient (all ones).
  localparam logic DBZ_Q_BIT = 1'b1;

  // Iteration counter must hold values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/nbit_seq_divider_sub.sv
// Structural ripple-carry 2's-complement subtractor: diff = a + ~b + c_in.
// c_out = 1 means no borrow, i.e. a >= b when c_in = 1.
module NBitSub #(
  parameter int n = 9
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] diff,
  output logic         c_out
);

  logic [n:0]   carry;
  logic [n-1:0] b_inv;

  assign b_inv    = ~b;
  assign carry[0] = c_in;

  // One full adder per bit, carry rippling from LSB to MSB.
  for (genvar i = 0; i < n; i++) begin : g_fa
    assign diff[i]      = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign c_out = carry[n];

endmodule

// File: rtl/nbit_seq_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | iterating, one quotient bit per clock
//   DONE  | results valid, done pulses; start here is accepted again
module nbit_seq_divider
  import nbit_seq_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW           = cnt_width(N);
  localparam logic [CW-1:0]  LAST_CNT     = CW'(N - 1);
  localparam logic [N-1:0]   DBZ_QUOTIENT = {N{DBZ_Q_BIT}};

  state_t        state_q, state_d;
  logic [N-1:0]  d_q;
  logic [N-1:0]  q_q;
  logic [N:0]    r_q;
  logic [CW-1:0] cnt_q;

  logic [N:0]    rs;
  logic [N:0]    d_ext;
  logic [N:0]    t;
  logic          no_borrow;
  logic [N-1:0]  q_next;
  logic [N:0]    r_next;
  logic          accept;
  logic          last_iter;
  logic          div_zero_in;

  // R[N] is always 0 after an iteration; only the low N bits feed the shift.
  logic          unused_r_msb;
  assign unused_r_msb = r_q[N];

  assign accept      = start && (state_q != RUN);
  assign last_iter   = (state_q == RUN) && (cnt_q == LAST_CNT);
  assign div_zero_in = (divisor == '0);

  // Shift the next dividend bit into the partial remainder and trial-subtract D.
  assign rs    = {r_q[N-1:0], q_q[N-1]};
  assign d_ext = {1'b0, d_q};

  NBitSub #(
    .n (N + 1)
  ) u_sub (
    .a     (rs),
    .b     (d_ext),
    .c_in  (1'b1),
    .diff  (t),
    .c_out (no_borrow)
  );

  assign r_next = no_borrow ? t : rs;
  assign q_next = {q_q[N-2:0], no_borrow};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a zero divisor skips RUN and completes immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = div_zero_in ? DONE : RUN;
      end
      RUN: begin
        if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        if (start) state_d = div_zero_in ? DONE : RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working registers and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      d_q   <= divisor;
      q_q   <= dividend;
      r_q   <= '0;
      cnt_q <= '0;
      if (div_zero_in) begin
        quotient    <= DBZ_QUOTIENT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state_q == RUN) begin
      q_q   <= q_next;
      r_q   <= r_next;
      cnt_q <= cnt_q + CW'(1);
      if (last_iter) begin
        quotient    <= q_next;
        remainder   <= r_next[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_nbit_seq_divider.sv
// Self-checking bench for nbit_seq_divider (N=8) against a plain-arithmetic model.
module tb_nbit_seq_divider;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_fail = 0;

  nbit_seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                       output int edge_n);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; edge_n = 0;
    end else begin
      q = a / b; r = a % b; z = 1'b0; edge_n = N;
    end
  endtask

  // Issue one operation from IDLE. done_edge is the edge index (accepting edge = 0)
  // after which done is first seen; -1 if it never came.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output int done_edge, output int busy_cnt,
                        output logic [N-1:0] q, output logic [N-1:0] r, output logic z,
                        output logic done_after);
    start = 1'b1; dividend = a; divisor = b;
    step();
    start = 1'b0; dividend = N'($urandom); divisor = N'($urandom);
    done_edge = 0; busy_cnt = 0;
    while (!done && done_edge < 20) begin
      if (busy) busy_cnt++;
      step();
      done_edge++;
    end
    if (!done) done_edge = -1;
    q = quotient; r = remainder; z = div_by_zero;
    step();
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    step();
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0; start = 1'b0;
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    int de, bc;
    logic [N-1:0] q, r;
    logic z, da;
    run_op(8'd100, 8'd7, de, bc, q, r, z, da);
    n_cmp++;
    if ({q, r, z} !== {8'd14, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got %0d r %0d dbz=%0b, required 14 r 2 dbz=0", q, r, z);
    end
    n_cmp++;
    if (de !== N) begin
      n_fail++;
      $display("FAIL basic_latency: done after edge %0d, required %0d", de, N);
    end
    n_cmp++;
    if (bc !== N) begin
      n_fail++;
      $display("FAIL basic_busy: busy for %0d cycles, required %0d", bc, N);
    end
    n_cmp++;
    if (da !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%0b one cycle later, required 0", da);
    end
    repeat (3) step();
    n_cmp++;
    if ({quotient, remainder, div_by_zero, done, busy} !== {8'd14, 8'd2, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_hold: q=%0d r=%0d dbz=%0b done=%0b busy=%0b, required 14 2 0 0 0",
               quotient, remainder, div_by_zero, done, busy);
    end
  endtask

  task automatic test_boundaries();
    logic [N-1:0] ta [5] = '{8'd255, 8'd255, 8'd0,  8'd5, 8'd200};
    logic [N-1:0] tb [5] = '{8'd1,   8'd255, 8'd13, 8'd9, 8'd0};
    logic [N-1:0] eq [5] = '{8'd255, 8'd1,   8'd0,  8'd0, 8'hFF};
    logic [N-1:0] er [5] = '{8'd0,   8'd0,   8'd0,  8'd5, 8'd200};
    logic         ez [5] = '{1'b0,   1'b0,   1'b0,  1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      int de, bc, ede;
      logic [N-1:0] q, r;
      logic z, da;
      ede = (i == 4) ? 0 : N;
      run_op(ta[i], tb[i], de, bc, q, r, z, da);
      n_cmp++;
      if ({q, r, z} !== {eq[i], er[i], ez[i]}) begin
        n_fail++;
        $display("FAIL boundary_%0d_result: %0d/%0d got %0d r %0d dbz=%0b, required %0d r %0d dbz=%0b",
                 i, ta[i], tb[i], q, r, z, eq[i], er[i], ez[i]);
      end
      n_cmp++;
      if (de !== ede || bc !== ede) begin
        n_fail++;
        $display("FAIL boundary_%0d_timing: done edge %0d busy %0d, required %0d and %0d",
                 i, de, bc, ede, ede);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    start = 1'b0; e = 0;
    repeat (2) begin step(); e++; end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    step(); e++;
    start = 1'b0; dividend = 8'hA5; divisor = 8'h00;
    while (!done && e < 20) begin step(); e++; end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0} || e !== N) begin
      n_fail++;
      $display("FAIL ignore_start: got %0d r %0d dbz=%0b at edge %0d, required 14 r 2 dbz=0 at edge %0d",
               quotient, remainder, div_by_zero, e, N);
    end
    start = 1'b1; dividend = 8'd81; divisor = 8'd9;
    step();
    start = 1'b0; dividend = 8'd3; divisor = 8'd1;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%0b done=%0b, required 1 0", busy, done);
    end
    e = 0;
    while (!done && e < 20) begin step(); e++; end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {8'd9, 8'd0, 1'b0} || e !== N) begin
      n_fail++;
      $display("FAIL b2b_result: got %0d r %0d dbz=%0b at edge %0d, required 9 r 0 dbz=0 at edge %0d",
               quotient, remainder, div_by_zero, e, N);
    end
    step();
  endtask

  task automatic test_abort();
    int de, bc, stray;
    logic [N-1:0] q, r;
    logic z, da;
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, quotient, remainder, div_by_zero} !== {1'b0, 1'b0, 8'd0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_state: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    stray = 0;
    repeat (15) begin
      if (done || busy) stray++;
      step();
    end
    n_cmp++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d cycles with done/busy after abort, required 0", stray);
    end
    run_op(8'd17, 8'd4, de, bc, q, r, z, da);
    n_cmp++;
    if ({q, r, z} !== {8'd4, 8'd1, 1'b0} || de !== N) begin
      n_fail++;
      $display("FAIL abort_recover: got %0d r %0d dbz=%0b at edge %0d, required 4 r 1 dbz=0 at edge %0d",
               q, r, z, de, N);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      int de, bc, ede;
      logic [N-1:0] a, b, q, r, mq, mr;
      logic z, mz, da;
      int sel;
      a = N'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      b = '0;
      else if (sel == 1) b = N'($urandom_range(1, 15));
      else               b = N'($urandom);
      model(a, b, mq, mr, mz, ede);
      run_op(a, b, de, bc, q, r, z, da);
      n_cmp++;
      if ({q, r, z} !== {mq, mr, mz}) begin
        n_fail++;
        $display("FAIL random_%0d_result: %0d/%0d got %0d r %0d dbz=%0b, required %0d r %0d dbz=%0b",
                 i, a, b, q, r, z, mq, mr, mz);
      end
      n_cmp++;
      if (de !== ede || bc !== ede || da !== 1'b0) begin
        n_fail++;
        $display("FAIL random_%0d_timing: %0d/%0d done edge %0d busy %0d done_after %0b, required %0d %0d 0",
                 i, a, b, de, bc, da, ede, ede);
      end
    end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nbit_seq_divider.md
Name: nbit_seq_divider

Overview:
- Multi-cycle unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
- Performs one trial subtraction per clock, reusing the team's structural 2's-complement subtractor as its datapath.
- Sits beside the ALU as its iterative counterpart to subtraction; the ALU or a test controller drives it through a start/done handshake.

Parameters:
- N, 8, operand, quotient and remainder width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- dividend  input  N  unsigned dividend; captured on the accepting edge.
- divisor  input  N  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results are valid.
- quotient  output  N  result; held until the next accepted start.
- remainder  output  N  result; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor == 0; held with the results.

Behaviour:
- Reset: synchronous on rst high. State goes to IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. rst overrides start and aborts any operation in flight; no done is issued for an aborted operation.
- States and transitions:
  - IDLE: waits for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
  - IDLE -> RUN on start. DONE -> IDLE when start is low. DONE -> RUN when start is high (back-to-back accepted). RUN -> DONE after N iterations.
- Accept (edge 0, start=1 in IDLE or DONE):
  - Latch divisor into D.
  - Q <= dividend, R (N+1 bits) <= 0, counter <= 0.
  - If divisor != 0: state RUN, busy=1.
  - div_by_zero, quotient and remainder keep their old values until completion.
- Iteration (edges 1..N, RUN):
  - Rs = {R[N-1:0], Q[N-1]}.
  - T = Rs + ~{1'b0,D} + 1, via the (N+1)-bit subtractor with c_in tied 1.
  - Subtractor c_out = 1 means Rs >= D: R <= T, Q <= {Q[N-2:0],1}.
  - c_out = 0: R <= Rs, Q <= {Q[N-2:0],0}.
  - counter increments.
- Completion (edge N): quotient <= Q-next, remainder <= R-next[N-1:0], div_by_zero <= 0, state DONE, done=1, busy=0.
- Latency: done is high in the cycle after edge N, i.e. N cycles after the accepting edge, for exactly one cycle.
- Divide by zero (divisor == 0 at accept): edge 0 goes directly to DONE with quotient = all ones, remainder = dividend, div_by_zero=1, done=1. busy stays 0. Latency is 1 cycle.
- start while busy: ignored; the in-flight operation and its operands are unaffected.
- Input changes after accept: no effect.
- Invariant: R[N] is 0 after every iteration. Final remainder < D.
- dividend < divisor: quotient=0, remainder=dividend.

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - counter width $clog2(N+1);
  - the div-by-zero quotient constant (all ones).
- One sub-module instance: NBitSub with n=N+1 and c_in tied to 1'b1, providing T and c_out. The control FSM and Q/R/counter registers stay in nbit_seq_divider.

Test Plan:
- N=8, dividend=100, divisor=7, start pulsed 1 cycle -> busy high for 8 cycles; done pulses 8 cycles after accept with quotient=14, remainder=2, div_by_zero=0; outputs hold afterward.
- 255/1, then 255/255, then 0/13 -> (255,0), (1,0), (0,0), each with 8-cycle latency.
- 5/9 -> quotient=0, remainder=5. Then 200/0 -> done 1 cycle after accept with quotient=0xFF, remainder=200, div_by_zero=1, busy never high.
- Start 100/7. Pulse start with 50/5 at cycle 3 and change the inputs -> ignored; result is still 14 r 2 at cycle 8. Start held high at the done cycle with 81/9 -> accepted back-to-back; 9 r 0 arrives 8 cycles later.
- Start 100/7. Assert rst at cycle 4 -> next edge: busy=0, done=0, outputs 0, no done pulse later. A new start 17/4 then yields 4 r 1.
- Random sweep (1000 pairs, including divisor=0) against a reference model -> every quotient/remainder/div_by_zero matches, and done latency is exactly 8 cycles (1 cycle for divisor=0).
